mem_resp: RTL
=============

# mem_resp

Bus responder for the 8-bit accumulator CPU, sitting on the far side of its `rd`/`wr`/`addr[12:0]`/`data[7:0]` bus. It holds the 8K×8 program/data store and a loader port that fills memory while the CPU is held off. After loading, it serves CPU reads with registered data and accepts CPU writes to the RAM region. It flags write-protect violations and illegal bus cycles.

## Interface
- `ADDR_W`, 13: address width; memory depth is 2^ADDR_W.
- `DATA_W`, 8: data width.
- `ROM_TOP`, 13'h1800: addresses below this are read-only to the CPU; addresses at or above it are RAM.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rd`  in  1  CPU read strobe.
- `wr`  in  1  CPU write strobe.
- `addr`  in  ADDR_W  CPU address.
- `data`  inout  DATA_W  CPU data bus; driven only during an accepted read, Hi-Z otherwise.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  loader beat accepted when `ld_valid & ld_ready`.
- `ld_addr`  in  ADDR_W  loader write address.
- `ld_data`  in  DATA_W  loader write data.
- `ld_last`  in  1  marks final loader beat.
- `cpu_hold`  out  1  high while loading; the system keeps the CPU in reset while this is high.
- `ld_count`  out  ADDR_W+1  number of accepted loader beats since reset.
- `wp_err`  out  1  sticky: CPU wrote below `ROM_TOP`.
- `ill_err`  out  1  sticky: `rd` and `wr` high together.

## Operation
- Two-state FSM: LOAD and RUN. Reset (`reset`=0 at an edge) forces LOAD.
- LOAD:
  - `cpu_hold`=1, `ld_ready`=1; CPU bus is ignored and `data` is Hi-Z.
  - Each accepted beat writes `mem[ld_addr] <= ld_data` to any address (ROM or RAM) and increments `ld_count`.
  - An accepted beat with `ld_last`=1 moves the FSM to RUN.
  - `ld_valid` low: nothing happens; `ld_last` is ignored without `ld_valid`.
- RUN:
  - `ld_ready`=0, `cpu_hold`=0; loader inputs are ignored.
  - `rd`=1, `wr`=0: `rdata <= mem[addr]` every cycle while `rd` is high. A cycle flag `rd_q` is set.
  - `data` is driven with `rdata` when `rd & rd_q & ~wr`, otherwise Hi-Z.
  - `wr`=1, `rd`=0, `addr >= ROM_TOP`: `mem[addr] <= data` on each cycle `wr` is high; repeated writes are idempotent.
  - `wr`=1, `rd`=0, `addr < ROM_TOP`: no write; `wp_err` <= 1.
  - `rd`=1, `wr`=1: no read and no write; `data` Hi-Z; `ill_err` <= 1.
  - `rd`=0, `wr`=0: idle; `data` Hi-Z.
- Arithmetic: `ld_count` saturates at 2^ADDR_W and does not wrap. Addresses are used modulo 2^ADDR_W.
- Memory contents are not cleared by reset. They persist across reset and are not initialised (X) before the first load.

## Timing
- Reset values:
  - FSM = LOAD, `cpu_hold`=1, `ld_ready`=1.
  - `ld_count`=0, `wp_err`=0, `ill_err`=0.
  - `rdata`=0, `rd_q`=0, `data` Hi-Z.
- Load: beat accepted at edge N → memory written at edge N. If `ld_last`, `cpu_hold`=0 and `ld_ready`=0 from edge N onward (registered outputs).
- Read latency is 1 cycle:
  - `rd` first sampled high at edge N → `data` valid after edge N and held while `rd` stays high.
  - If `addr` changes during `rd`, new data appears after the next edge.
  - `rd` falling → `data` Hi-Z combinationally, and `rd_q` clears at the next edge.
- Write: takes effect at the edge where `wr` is sampled high. A read of the same address in a later cycle returns the new value.
- Error flags set at the edge the offending cycle is sampled. They clear only on reset.
- Reset mid-operation:
  - Mid-load: partial contents are kept and `ld_count` returns to 0.
  - Mid-read: `data` goes Hi-Z after the reset edge.
  - In all cases the FSM re-enters LOAD and a new load is required before RUN.

## Test plan
- Apply reset low for 2 cycles, then high → `cpu_hold`=1, `ld_ready`=1, `ld_count`=0, `wp_err`=`ill_err`=0, `data` Hi-Z; toggling `rd` has no effect.
- Load beats (0x0000,0xA5), (0x0001,0x3C), (0x0002,0xFF) with `ld_last` on the third → `ld_count`=3, and `cpu_hold`/`ld_ready` fall after the third edge. A fourth `ld_valid` beat is not accepted.
- RUN, `rd`=1 with `addr`=0x0001 → `data`=0x3C one cycle later. Switch `addr` to 0x0000 while `rd` is held → `data`=0xA5 after the next edge. Drop `rd` → `data` Hi-Z immediately.
- `wr` to 0x1800 with `data`=0x5A, then read 0x1800 → 0x5A.
- `wr` to 0x0002 with `data`=0x00 → `wp_err`=1; a read of 0x0002 still returns 0xFF.
- `rd`=`wr`=1 at 0x1800 with bus value 0x11 → `ill_err`=1, `data` not driven, and a later read of 0x1800 still returns 0x5A.
- Reset low during a read, then reload one beat (0x1FFF,0x77, `ld_last`) → `ld_count`=1. Reads of 0x0001 (0x3C) and 0x1FFF (0x77) confirm contents were preserved and updated.

Source files
------------

// File: rtl/mem_resp_if.sv
// rtl/mem_resp_if.sv - CPU strobe/address bus, loader stream and status bundle for mem_resp
interface mem_resp_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) ();
  // CPU side (data bus itself stays a plain inout on the responder)
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  // loader beat stream
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  // status
  logic              cpu_hold;
  logic [ADDR_W:0]   ld_count;
  logic              wp_err;
  logic              ill_err;

  modport master (
    output rd, wr, addr, ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, cpu_hold, ld_count, wp_err, ill_err
  );

  modport slave (
    input  rd, wr, addr, ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, cpu_hold, ld_count, wp_err, ill_err
  );
endinterface

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - program/data store responder with loader port, write protect and bus error flags
module mem_resp #(
  parameter int                ADDR_W  = 13,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] ROM_TOP = 13'h1800
) (
  input  logic              clk,
  input  logic              reset,
  mem_resp_if.slave         bus,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  // ld_count stops here rather than wrapping back to zero
  localparam logic [ADDR_W:0] LD_SAT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  state_t            state_q, state_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              ld_ready_q, ld_ready_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              wp_err_q, wp_err_d;
  logic              ill_err_q, ill_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              drive_en;

  // next-state, loader acceptance and CPU cycle decode
  always_comb begin
    state_d    = state_q;
    cpu_hold_d = cpu_hold_q;
    ld_ready_d = ld_ready_q;
    ld_count_d = ld_count_q;
    wp_err_d   = wp_err_q;
    ill_err_d  = ill_err_q;
    rdata_d    = rdata_q;
    rd_d       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = bus.ld_addr;
    mem_wdata  = bus.ld_data;
    case (state_q)
      S_LOAD: begin
        if (bus.ld_valid && ld_ready_q) begin
          mem_we = 1'b1;
          if (ld_count_q != LD_SAT) ld_count_d = ld_count_q + 1'b1;
          if (bus.ld_last) begin
            state_d    = S_RUN;
            cpu_hold_d = 1'b0;
            ld_ready_d = 1'b0;
          end
        end
      end
      default: begin
        if (bus.rd && bus.wr) begin
          ill_err_d = 1'b1;
        end else if (bus.rd) begin
          rdata_d = mem[bus.addr];
          rd_d    = 1'b1;
        end else if (bus.wr) begin
          if (bus.addr >= ROM_TOP) begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr;
            mem_wdata = data;
          end else begin
            wp_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // control/status registers; memory contents are deliberately outside reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      cpu_hold_q <= 1'b1;
      ld_ready_q <= 1'b1;
      ld_count_q <= '0;
      wp_err_q   <= 1'b0;
      ill_err_q  <= 1'b0;
      rdata_q    <= '0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
      ld_ready_q <= ld_ready_d;
      ld_count_q <= ld_count_d;
      wp_err_q   <= wp_err_d;
      ill_err_q  <= ill_err_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
    end
  end

  // single write port shared by loader and CPU
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // bus released the moment rd drops or wr joins it
  assign drive_en = bus.rd & rd_q & ~bus.wr;
  assign data     = drive_en ? rdata_q : {DATA_W{1'bz}};

  assign bus.ld_ready = ld_ready_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.ld_count = ld_count_q;
  assign bus.wp_err   = wp_err_q;
  assign bus.ill_err  = ill_err_q;

endmodule
